// File: rtl/mad_dot_sequencer.sv
// Sequential dot-product controller around one shared multiply-add datapath (a*b + acc).
// Build option: define MAD_DOT_SAT_EN to saturate the accumulator on carry-out instead of wrapping.
module mad_dot_sequencer #(
    parameter int INPUT_WIDTH = 16,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_WIDTH-1:0]       len,
    input  logic [2*INPUT_WIDTH-1:0]   acc_init,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUT_WIDTH-1:0]     a,
    input  logic [INPUT_WIDTH-1:0]     b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*INPUT_WIDTH-1:0]   result,
    output logic                       overflow
);

    localparam int ACC_W = 2 * INPUT_WIDTH;
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_n_s;
    logic [ACC_W-1:0]     acc_r;
    logic [ACC_W-1:0]     acc_n_s;
    logic [LEN_WIDTH-1:0] count_r;
    logic [LEN_WIDTH-1:0] count_n_s;
    logic                 overflow_r;
    logic                 overflow_n_s;
    logic                 busy_r;
    logic                 in_ready_r;
    logic                 out_valid_r;

    logic [ACC_W-1:0]     prod_s;
    logic [ACC_W:0]       sum_s;
    logic [ACC_W-1:0]     acc_beat_s;
    logic                 beat_s;

    // Shared datapath: full-width product plus accumulator with one carry bit.
    always_comb begin
        prod_s = {{INPUT_WIDTH{1'b0}}, a} * {{INPUT_WIDTH{1'b0}}, b};
        sum_s  = {1'b0, prod_s} + {1'b0, acc_r};
        beat_s = in_ready_r & in_valid;
`ifdef MAD_DOT_SAT_EN
        acc_beat_s = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
`else
        acc_beat_s = sum_s[ACC_W-1:0];
`endif
    end

    // Next-state and next-datapath selection for the job sequencer.
    always_comb begin
        state_n_s    = state_r;
        acc_n_s      = acc_r;
        count_n_s    = count_r;
        overflow_n_s = overflow_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_n_s      = acc_init;
                    overflow_n_s = 1'b0;
                    if (len != LEN_ZERO) begin
                        count_n_s = len;
                        state_n_s = ST_ACCUM;
                    end else begin
                        count_n_s = LEN_ZERO;
                        state_n_s = ST_DONE;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (beat_s) begin
                    acc_n_s      = acc_beat_s;
                    overflow_n_s = overflow_r | sum_s[ACC_W];
                    count_n_s    = count_r - LEN_ONE;
                    if (count_r == LEN_ONE) begin
                        state_n_s = ST_DONE;
                    end else begin
                        state_n_s = ST_ACCUM;
                    end
                end else begin
                    state_n_s = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: begin
                state_n_s    = ST_IDLE;
                acc_n_s      = {ACC_W{1'b0}};
                count_n_s    = LEN_ZERO;
                overflow_n_s = 1'b0;
            end
        endcase
    end

    // State registers; handshake flags are registered from the next state so they never see in_valid/out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= {ACC_W{1'b0}};
            count_r     <= LEN_ZERO;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            acc_r       <= acc_n_s;
            count_r     <= count_n_s;
            overflow_r  <= overflow_n_s;
            busy_r      <= (state_n_s != ST_IDLE);
            in_ready_r  <= (state_n_s == ST_ACCUM);
            out_valid_r <= (state_n_s == ST_DONE);
        end
    end

    assign busy      = busy_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = acc_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_mad_dot_sequencer.sv
// Self-checking bench for mad_dot_sequencer: directed scenarios plus randomized jobs against a sum-of-products model.
// Honours MAD_DOT_SAT_EN so the model matches the build under test.
module tb_mad_dot_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [31:0] acc_init;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;

    int n_checks;
    int n_fail;

    logic [15:0] pa  [0:255];
    logic [15:0] pb  [0:255];
    int          gap [0:255];

    mad_dot_sequencer #(.INPUT_WIDTH(16), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .acc_init(acc_init),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: initial value plus the sum of products, wrapped or clamped at 32 bits.
    function automatic logic [32:0] model(input logic [31:0] init, input int n);
        logic [63:0] acc;
        logic        ovf;
        acc = {32'd0, init};
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = acc + 64'(pa[i]) * 64'(pb[i]);
            if (acc > 64'h0000_0000_FFFF_FFFF) begin
                ovf = 1'b1;
`ifdef MAD_DOT_SAT_EN
                acc = 64'h0000_0000_FFFF_FFFF;
`else
                acc = acc & 64'h0000_0000_FFFF_FFFF;
`endif
            end
        end
        return {ovf, acc[31:0]};
    endfunction

    task automatic start_job(input int n, input logic [31:0] init);
        chk("idle_before_start", 64'(busy), 64'd0);
        start    = 1'b1;
        len      = 8'(n);
        acc_init = init;
        @(negedge clk);
        start    = 1'b0;
        len      = 8'($urandom);
        acc_init = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("in_ready_after_start", 64'(in_ready), (n != 0) ? 64'd1 : 64'd0);
        chk("out_valid_after_start", 64'(out_valid), (n == 0) ? 64'd1 : 64'd0);
    endtask

    task automatic feed_beats(input int n, input bit spurious);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                in_valid = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
                chk("in_ready_hold", 64'(in_ready), 64'd1);
                @(negedge clk);
            end
            in_valid = 1'b1;
            a = pa[i];
            b = pb[i];
            if (spurious && i == 0) begin
                start = 1'b1;
                len   = 8'd5;
            end
            chk("in_ready_beat", 64'(in_ready), 64'd1);
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input int n, input logic [31:0] init, input int hold, input bit spurious);
        logic [32:0] exp;
        exp = model(init, n);
        chk("out_valid_done", 64'(out_valid), 64'd1);
        chk("in_ready_done", 64'(in_ready), 64'd0);
        chk("result", 64'(result), 64'(exp[31:0]));
        chk("overflow", 64'(overflow), 64'(exp[32]));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk("out_valid_stall", 64'(out_valid), 64'd1);
            chk("result_stall", 64'(result), 64'(exp[31:0]));
            chk("overflow_stall", 64'(overflow), 64'(exp[32]));
            chk("in_ready_stall", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        if (spurious) begin
            start = 1'b1;
            len   = 8'd5;
        end
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("busy_after_handshake", 64'(busy), 64'd0);
        chk("out_valid_after_handshake", 64'(out_valid), 64'd0);
        chk("in_ready_after_handshake", 64'(in_ready), 64'd0);
    endtask

    task automatic run_job(input int n, input logic [31:0] init, input int hold, input bit spurious);
        start_job(n, init);
        feed_beats(n, spurious);
        finish_job(n, init, hold, spurious);
    endtask

    initial begin
        logic [31:0] init;
        int          n;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        acc_init  = 32'd0;
        in_valid  = 1'b0;
        a         = 16'd0;
        b         = 16'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) gap[i] = 0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back dot product: 2*3 + 4*5 + 6*7 = 68.
        pa[0] = 16'd2; pb[0] = 16'd3;
        pa[1] = 16'd4; pb[1] = 16'd5;
        pa[2] = 16'd6; pb[2] = 16'd7;
        run_job(3, 32'd0, 0, 1'b0);
        chk("directed_68", 64'(model(32'd0, 3)), 64'd68);

        // Zero-length job goes straight to the result.
        run_job(0, 32'h0000_1234, 1, 1'b0);

        // Stalled input and stalled output: 10 + 10000 + 56 = 10066.
        pa[0] = 16'd100; pb[0] = 16'd100; gap[1] = 3;
        pa[1] = 16'd7;   pb[1] = 16'd8;
        run_job(2, 32'd10, 5, 1'b0);
        gap[1] = 0;

        // Carry out of the accumulator.
        pa[0] = 16'd1; pb[0] = 16'd1;
        pa[1] = 16'd2; pb[1] = 16'd2;
        run_job(2, 32'hFFFF_FFFF, 1, 1'b0);

        // Reset in the middle of a job discards it.
        pa[0] = 16'd9; pb[0] = 16'd9;
        pa[1] = 16'd5; pb[1] = 16'd5;
        start_job(4, 32'd77);
        feed_beats(2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_stays_idle", 64'(busy), 64'd0);
        pa[0] = 16'd3; pb[0] = 16'd3;
        run_job(1, 32'd0, 0, 1'b0);

        // Start pulses during ACCUM and in the handshake cycle are ignored.
        pa[0] = 16'd11; pb[0] = 16'd12;
        pa[1] = 16'd13; pb[1] = 16'd14;
        pa[2] = 16'd15; pb[2] = 16'd16;
        run_job(3, 32'd1000, 2, 1'b1);

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            n = $urandom_range(0, 12);
            if ((j % 4) == 3) begin
                init = 32'hFFF0_0000 | 32'($urandom_range(0, 32'h000F_FFFF));
            end else begin
                init = $urandom;
            end
            for (int i = 0; i < n; i++) begin
                pa[i]  = 16'($urandom);
                pb[i]  = 16'($urandom);
                gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
            run_job(n, init, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 256; i++) gap[i] = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mad_dot_sequencer.md
# mad_dot_sequencer

Sequential dot-product controller around one shared multiply-add datapath (`a*b + c`). It accepts a job (vector length plus initial accumulator) and streams operand pairs over a valid/ready channel. The accumulator is fed back as the addend each beat, and the final 2W-bit sum is presented on a valid/ready result channel. It sits between operand-fetch logic and the result writeback in the math subsystem.

## Interface
- `INPUT_WIDTH`, default 16: operand width W; accumulator/result width is 2W.
- `LEN_WIDTH`, default 8: width of job length field; max job = 2^LEN_WIDTH−1 beats.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: job request; accepted only in IDLE.
- `len` input LEN_WIDTH: number of operand pairs in job; sampled with accepted `start`.
- `acc_init` input 2W: initial accumulator; sampled with accepted `start`.
- `busy` output 1: high in any state other than IDLE.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: operand pair accepted when `in_valid & in_ready`.
- `a`, `b` input W each: unsigned operands.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid & out_ready`.
- `result` output 2W: accumulated sum.
- `overflow` output 1: sticky per job; set if any beat's add carried out of 2W bits.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: `start=1` and `len!=0` → load acc=`acc_init`, count=`len`, clear overflow, go ACCUM. `start=1` and `len==0` → load acc=`acc_init`, clear overflow, go DONE directly. `start=0` → stay.
- ACCUM: `in_ready=1`. On accepted beat: sum = {1'b0,a*b} + {1'b0,acc} at 2W+1 bits; acc ← sum[2W−1:0]; overflow ← overflow | sum[2W]; count ← count−1. Accepted beat with count==1 → DONE. No beat → hold all state.
- DONE: `out_valid=1`, `result`=acc; on `out_ready` → IDLE. `in_ready=0`.
- `start` outside IDLE is ignored (no effect on job, no queueing), including `start` in the DONE cycle where the result handshake completes.
- Arithmetic unsigned throughout; product is full 2W bits, no truncation.
- `rst` in any state: next cycle IDLE, acc=0, count=0, overflow=0; in-flight job discarded, no `out_valid` pulse.

## Timing
- Reset values: `busy=0`, `in_ready=0`, `out_valid=0`, `result=0`, `overflow=0`.
- `in_ready`, `out_valid`, `busy` decode from registered state only; no combinational path from `in_valid`/`out_ready` to them.
- `start` accepted at edge t → `busy=1` and (len!=0) `in_ready=1` from cycle t+1.
- Throughput: one operand pair per cycle in ACCUM.
- Last beat accepted at edge t → `out_valid=1` with final `result`/`overflow` from cycle t+1.
- `len==0`: `out_valid=1` in cycle t+1 after `start`.
- `result`/`overflow` stable while `out_valid=1` and `out_ready=0`.
- Result handshake at edge t → IDLE at t+1; earliest next `start` accepted at edge t+1.
- Job latency with no stalls: len+1 cycles from `start` to `out_valid`.

## Configuration
- `MAD_DOT_SAT_EN` defined: on a beat with carry-out, acc ← all-ones (2^(2W)−1); acc then stays saturated for the rest of the job; `overflow` sets as usual.
- Undefined: acc wraps modulo 2^(2W); `overflow` still flags the carry.

## Test plan
- W=16, len=3, acc_init=0, pairs (2,3),(4,5),(6,7) back-to-back → `out_valid` one cycle after 3rd beat, `result`=68, `overflow`=0.
- len=0, acc_init=0x00001234 → `in_ready` never high, `out_valid` cycle after start, `result`=0x00001234.
- len=2, acc_init=10, (100,100) then 3 idle cycles then (7,8); hold `out_ready=0` for 5 cycles → `result`=10066 stable throughout, `in_ready=0` in DONE, IDLE cycle after `out_ready=1`.
- acc_init=0xFFFFFFFF, len=2, pairs (1,1),(2,2) → `overflow`=1; without macro `result`=0x00000004; with `MAD_DOT_SAT_EN` `result`=0xFFFFFFFF.
- len=4, assert `rst` after 2 accepted beats → next cycle `busy=0`, `in_ready=0`, `out_valid=0`; new job len=1, acc_init=0, (3,3) → `result`=9.
- `start` pulsed with len=5 during ACCUM and in DONE handshake cycle → ignored; original job result unchanged, `busy=0` after handshake.
